// File: rtl/spi_cmd_slave.sv
// SPI mode-0 command slave: oversamples sclk/mosi/ss_n, decodes 40-bit R/W frames into register-bank strobes.
// Latency: a pin edge is acted on SYNC_STAGES+1 clocks later; wr_valid follows the last data bit by one clock.
// Backpressure: none; the bank must take every strobe and present rd_data the cycle after rd_req.
module spi_cmd_slave #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              frame_error
);

  localparam int HDR_W = 1 + ADDR_W;
  localparam int SH_W  = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int CNT_W = $clog2(SH_W + 1);

  typedef enum logic [1:0] {IDLE, HEADER, WR_DATA, RD_DATA} state_t;

  logic [SYNC_STAGES-1:0] sclk_q, mosi_q, ss_q;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, mosi_s, ss_s;
  logic                   sclk_rise, sclk_fall, ss_rise;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  // The final bit of each field comes straight from mosi_s, so only SH_W-1 bits are stored.
  logic [SH_W-2:0]   sh;
  logic [DATA_W-1:0] tx;
  logic [ADDR_W-1:0] cur_addr;
  logic              load_pend;
  logic [HDR_W-1:0]  hdr_word;
  logic [DATA_W-1:0] data_word;

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign ss_s      = ss_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;

  assign hdr_word  = {sh[HDR_W-2:0], mosi_s};
  assign data_word = {sh[DATA_W-2:0], mosi_s};

  // tx is cleared whenever a read ends, so miso idles low straight from a flop.
  assign miso = tx[DATA_W-1];

  // Synchronise the pad inputs and keep one extra stage of sclk/ss_n for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_q <= '0;
      mosi_q <= '0;
      ss_q   <= '1;
      sclk_d <= 1'b0;
      ss_d   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], ss_n};
      sclk_d <= sclk_s;
      ss_d   <= ss_s;
    end
  end

  // Frame FSM: header decode, write strobe, read fetch/shift-out and abort handling.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      sh          <= '0;
      tx          <= '0;
      cur_addr    <= '0;
      load_pend   <= 1'b0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      frame_error <= 1'b0;
    end else begin
      wr_valid    <= 1'b0;
      rd_req      <= 1'b0;
      frame_error <= 1'b0;
      load_pend   <= rd_req;

      // Bank word arrives the cycle after rd_req; later clears in this block take priority.
      if (load_pend && state == RD_DATA) begin
        tx <= rd_data;
      end

      if (state == IDLE) begin
        bit_cnt <= '0;
        if (!ss_s) begin
          state <= HEADER;
        end
      end else if (ss_rise) begin
        // Abort beats any sclk edge seen in the same cycle.
        state       <= IDLE;
        bit_cnt     <= '0;
        tx          <= '0;
        frame_error <= (bit_cnt != '0) || (state == RD_DATA);
      end else if (sclk_rise && !ss_s) begin
        sh      <= {sh[SH_W-3:0], mosi_s};
        bit_cnt <= bit_cnt + 1'b1;
        case (state)
          HEADER: begin
            if (bit_cnt == CNT_W'(HDR_W - 1)) begin
              bit_cnt  <= '0;
              cur_addr <= hdr_word[ADDR_W-1:0];
              if (hdr_word[HDR_W-1]) begin
                rd_req  <= 1'b1;
                rd_addr <= hdr_word[ADDR_W-1:0];
                state   <= RD_DATA;
              end else begin
                state <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt  <= '0;
              wr_valid <= 1'b1;
              wr_addr  <= cur_addr;
              wr_data  <= data_word;
              state    <= HEADER;
            end
          end
          RD_DATA: begin
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt <= '0;
              tx      <= '0;
              state   <= HEADER;
            end
          end
          default: ;
        endcase
      end else if (sclk_fall && state == RD_DATA && bit_cnt != '0) begin
        // The falling edge that closes the header is skipped so the MSB is
        // still on miso for the first data rising edge.
        tx <= {tx[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule
